// File: rtl/pipeemreg_io.sv
// pipeemreg_io: EX/MEM pipeline register of the IO-capable pipelined CPU.
// A latched load or store that targets the memory-mapped IO region
// (ealu[IO_SEL_BIT] == 1) holds the M stage for WAIT_CYCLES extra cycles.
// During those cycles it stalls the upstream pipeline and masks the
// write enables, so the IO access commits exactly once.
// Optional feature: define IO_PERF_CNT_EN to add the saturating
// io_stall_cnt performance counter port.
module pipeemreg_io #(
    parameter int WAIT_CYCLES = 1,
    parameter int IO_SEL_BIT  = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    input  logic        eflush,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [31:0] malu,
    output logic [31:0] mb,
    output logic [4:0]  mrn,
    output logic        io_stall
`ifdef IO_PERF_CNT_EN
    ,
    output logic [15:0] io_stall_cnt
`endif
);

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    logic        r_wreg;
    logic        r_m2reg;
    logic        r_wmem;
    logic [31:0] r_alu;
    logic [31:0] r_b;
    logic [4:0]  r_rn;
    logic [2:0]  cnt;
    logic        io_access;

    // The stall comes only from registered state, so it has no input-to-output path
    assign io_stall  = (cnt != 3'd0);
    assign io_access = (ewmem | em2reg) & ~eflush & ealu[IO_SEL_BIT];

    // Capture the EX instruction when not stalled; a flush keeps the data but drops the controls
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wreg  <= 1'b0;
            r_m2reg <= 1'b0;
            r_wmem  <= 1'b0;
            r_alu   <= 32'd0;
            r_b     <= 32'd0;
            r_rn    <= 5'd0;
        end else if (!io_stall) begin
            r_wreg  <= ewreg  & ~eflush;
            r_m2reg <= em2reg & ~eflush;
            r_wmem  <= ewmem  & ~eflush;
            r_alu   <= ealu;
            r_b     <= eb;
            r_rn    <= ern;
        end
    end

    // Wait counter: armed by an IO access on a load edge, counted down while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= 3'd0;
        end else if (io_stall) begin
            cnt <= cnt - 3'd1;
        end else if (io_access) begin
            cnt <= WAIT_INIT;
        end else begin
            cnt <= 3'd0;
        end
    end

    // Write enables are masked while waiting; everything else passes straight through
    assign mwreg  = r_wreg & ~io_stall;
    assign mwmem  = r_wmem & ~io_stall;
    assign mm2reg = r_m2reg;
    assign malu   = r_alu;
    assign mb     = r_b;
    assign mrn    = r_rn;

`ifdef IO_PERF_CNT_EN
    // Count every stalled edge, sticking at the maximum instead of wrapping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_stall_cnt <= 16'd0;
        end else if (io_stall && (io_stall_cnt != 16'hFFFF)) begin
            io_stall_cnt <= io_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeemreg_io.sv
// tb_pipeemreg_io: scoreboard bench for pipeemreg_io.
// The driver expands every latched instruction into its expected
// per-cycle M-stage output stream and queues it. A monitor pops one
// entry after every clock edge and compares it with the DUT outputs.
module tb_pipeemreg_io;

    localparam int W = 2;

    typedef struct packed {
        logic        stall;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
    } out_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ewreg = 1'b0;
    logic        em2reg = 1'b0;
    logic        ewmem = 1'b0;
    logic [31:0] ealu = 32'd0;
    logic [31:0] eb = 32'd0;
    logic [4:0]  ern = 5'd0;
    logic        eflush = 1'b0;
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [4:0]  mrn;
    logic        io_stall;
`ifdef IO_PERF_CNT_EN
    logic [15:0] io_stall_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    bit   checking = 1'b1;
    int   waitLeft = 0;
    int   perfModel = 0;
    out_t expQ[$];
    out_t zeroOut;

    pipeemreg_io #(.WAIT_CYCLES(W), .IO_SEL_BIT(7)) dut (
        .clock(clock),
        .reset(reset),
        .ewreg(ewreg),
        .em2reg(em2reg),
        .ewmem(ewmem),
        .ealu(ealu),
        .eb(eb),
        .ern(ern),
        .eflush(eflush),
        .mwreg(mwreg),
        .mm2reg(mm2reg),
        .mwmem(mwmem),
        .malu(malu),
        .mb(mb),
        .mrn(mrn),
        .io_stall(io_stall)
`ifdef IO_PERF_CNT_EN
        ,
        .io_stall_cnt(io_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    function automatic out_t actual();
        out_t a;
        a = {io_stall, mwreg, mm2reg, mwmem, malu, mb, mrn};
        return a;
    endfunction

    task automatic checkOutput(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got stall=%b wreg=%b m2reg=%b wmem=%b alu=%h b=%h rn=%0d, expected stall=%b wreg=%b m2reg=%b wmem=%b alu=%h b=%h rn=%0d",
                     name, act.stall, act.wreg, act.m2reg, act.wmem, act.alu, act.b, act.rn,
                     exp.stall, exp.wreg, exp.m2reg, exp.wmem, exp.alu, exp.b, exp.rn);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs presented while the block is stalled must be ignored, so fill them with noise
    task automatic driveGarbage();
        ewreg  = 1'($urandom);
        em2reg = 1'($urandom);
        ewmem  = 1'($urandom);
        ealu   = $urandom;
        eb     = $urandom;
        ern    = 5'($urandom);
        eflush = 1'($urandom);
    endtask

    // Called at a falling edge; issues one instruction on the next edge the block accepts it
    task automatic applyStimulus(input logic wr, input logic m2r, input logic wm,
                                 input logic [31:0] alu, input logic [31:0] b,
                                 input logic [4:0] rn, input logic fl);
        out_t e;
        bit   isIo;
        repeat (waitLeft) begin
            driveGarbage();
            @(negedge clock);
        end
        ewreg = wr; em2reg = m2r; ewmem = wm; ealu = alu; eb = b; ern = rn; eflush = fl;
        isIo = (wm || m2r) && !fl && alu[7];
        e.wreg = 1'b0; e.wmem = 1'b0; e.stall = 1'b1;
        e.m2reg = m2r && !fl;
        e.alu = alu; e.b = b; e.rn = rn;
        if (isIo) begin
            for (int i = 0; i < W; i++) expQ.push_back(e);
        end
        e.stall = 1'b0;
        e.wreg  = wr && !fl;
        e.wmem  = wm && !fl;
        expQ.push_back(e);
        waitLeft  = isIo ? W : 0;
        perfModel = perfModel + waitLeft;
        @(negedge clock);
    endtask

    task automatic drain();
        repeat (waitLeft) begin
            driveGarbage();
            @(negedge clock);
        end
        waitLeft = 0;
        checkCount("queue_drained", expQ.size(), 0);
    endtask

    // Monitor: one expected entry per clock edge after an instruction is latched
    always @(posedge clock) begin
        #1;
        if (checking && expQ.size() > 0) begin
            out_t e;
            e = expQ.pop_front();
            checkOutput("m_stage", actual(), e);
        end
    end

    initial begin
        zeroOut = '0;

        // Reset state
        reset = 1'b1;
        #2;
        checkOutput("reset_state", actual(), zeroOut);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("after_reset_idle", actual(), zeroOut);

        // Directed: RAM store, IO store, IO load, flushed IO store
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 5'd3, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0084, 32'h0000_0000, 5'd9, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0088, 32'hCAFE_F00D, 5'd4, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 5'd7, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0180, 32'hAAAA_5555, 5'd1, 1'b0);
        drain();
`ifdef IO_PERF_CNT_EN
        checkCount("perf_directed", int'(io_stall_cnt), perfModel);
`endif

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                          5'($urandom), ($urandom_range(7) == 0));
        end
        drain();
`ifdef IO_PERF_CNT_EN
        checkCount("perf_random", int'(io_stall_cnt), perfModel);
`endif

        // Reset during an IO store wait must abort the store
        checking = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0090, 32'h5A5A_5A5A, 5'd2, 1'b0);
        reset = 1'b1;
        expQ.delete();
        waitLeft = 0;
        perfModel = 0;
        ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0; ealu = 32'd0; eb = 32'd0; ern = 5'd0; eflush = 1'b0;
        #1;
        checkOutput("reset_midwait", actual(), zeroOut);
        @(negedge clock);
        checkOutput("reset_held", actual(), zeroOut);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("post_reset_edge", actual(), zeroOut);
        @(negedge clock);
        checking = 1'b1;

        // Three IO accesses after reset
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0001, 5'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0002, 5'd5, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0003, 5'd0, 1'b0);
        drain();
`ifdef IO_PERF_CNT_EN
        checkCount("perf_three_io", int'(io_stall_cnt), 3 * W);
`endif

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_0000, 5'd31, 1'b0);
        checking = 1'b0;
        checkOutput("loaded_before_async", actual(),
                    {1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_0000, 5'd31});
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", actual(), zeroOut);
        @(negedge clock);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
